// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch queue and decode.
package fetch_pkg;
  localparam int INST_W = 32;
  localparam int BEAT_W = 64;
  localparam logic [INST_W-1:0] HALT_INST = 32'h0;
  typedef struct packed {
    logic [63:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: splits 64-bit fetch beats into PC-tagged instructions and queues them for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_halt,
  input  logic              flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    head_ent;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            halted, push, pop, odd, head_zero;
  logic [1:0]      n_push;
  assign head_ent  = mem[head];
  assign odd       = in_pc[2];
  assign head_zero = (count != '0) && (head_ent.inst == HALT_INST);
  assign in_ready  = (count <= CW'(DEPTH - 2)) && !flush;
  assign out_valid = (count != '0) && !halted && !flush && (head_ent.inst != HALT_INST);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign n_push    = push ? (odd ? 2'd1 : 2'd2) : 2'd0;
  assign out_pc    = out_valid ? PC_W'(head_ent.pc) : '0;
  assign out_inst  = out_valid ? head_ent.inst : '0;
  assign out_halt  = halted;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      head  <= head + AW'(pop);
      tail  <= tail + AW'(n_push);
      count <= count + CW'(n_push) - CW'(pop);
      if (head_zero) halted <= 1'b1;
    end
  end
  // An odd-word beat stores only its high word; the low word precedes the jump target.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= odd ? fetch_entry_t'{pc: 64'(in_pc), inst: in_data[63:32]}
                       : fetch_entry_t'{pc: 64'(in_pc), inst: in_data[31:0]};
      if (!odd) mem[tail + AW'(1)] <= fetch_entry_t'{pc: 64'(in_pc + PC_W'(4)), inst: in_data[63:32]};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 8;
  localparam int PC_W  = 64;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [PC_W-1:0]   in_pc = '0;
  logic [BEAT_W-1:0] in_data = '0;
  logic              in_ready, out_valid, out_halt;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  int n_chk = 0, n_pass = 0;
  fetch_entry_t q[$];
  logic m_halt = 1'b0;
  logic m_valid, m_ready, m_hz;
  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_halt(out_halt), .flush(flush)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Reference: a plain list of pending instructions plus a sticky halt flag.
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      q.delete();
      m_halt = 1'b0;
    end else begin
      m_valid = q.size() != 0 && !m_halt && q[0].inst != 0;
      m_ready = DEPTH - q.size() >= 2;
      m_hz    = q.size() != 0 && q[0].inst == 0;
      if (m_valid && out_ready) void'(q.pop_front());
      if (in_valid && m_ready) begin
        if (in_pc[2]) q.push_back('{pc: in_pc, inst: in_data[63:32]});
        else begin
          q.push_back('{pc: in_pc, inst: in_data[31:0]});
          q.push_back('{pc: in_pc + 4, inst: in_data[63:32]});
        end
      end
      if (m_hz) m_halt = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      logic ev;
      ev = q.size() != 0 && !m_halt && !flush && q[0].inst != 0;
      check("in_ready", 64'(in_ready), 64'((DEPTH - q.size() >= 2) && !flush));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("out_halt", 64'(out_halt), 64'(m_halt));
      check("count", 64'(dut.count), 64'(q.size()));
      check("out_pc", out_pc, ev ? q[0].pc : 64'h0);
      check("out_inst", 64'(out_inst), ev ? 64'(q[0].inst) : 64'h0);
    end
  end
  task automatic step(input logic v, input logic [63:0] pc, input logic [63:0] d,
                      input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_data = d; out_ready = rdy; flush = fl;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0);
  endtask
  initial begin
    #2;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_halt", 64'(out_halt), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step(1'b1, 64'h1000, 64'h00500093_00000013, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 64'h2004, 64'hDEADBEEF_00100113, 1'b1, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 64'h3000 + 64'(8 * i), {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)}, 1'b0, 1'b0);
    idle(12, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] pc;
      pc = {$urandom, $urandom} & ~64'h3;
      step($urandom_range(0, 3) != 0, pc, {$urandom | 32'h1, $urandom | 32'h1},
           $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end
    idle(10, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 64'h3000, 64'h00000000_00000013, 1'b1, 1'b0);
    idle(4, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h4000 + 64'(8 * i), 64'h11111111_22222222, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h5000 + 64'(8 * i), 64'h33333333_44444444, 1'b0, 1'b0);
    step(1'b1, 64'h6000, 64'h55555555_66666666, 1'b1, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 64'h7000 + 64'(8 * i), 64'h77777777_88888888, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async in_ready", 64'(in_ready), 64'd1);
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async out_halt", 64'(out_halt), 64'd0);
    check("async out_pc", out_pc, 64'd0);
    check("async out_inst", 64'(out_inst), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    step(1'b1, 64'h8004, 64'hCAFEF00D_00000000, 1'b1, 1'b0);
    idle(3, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
